// File: rtl/pcie_rq_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pcie_rq_arbiter
// Brief    : Round-robin sharing of the PCIe read/write request channels
//            between NUM_REQ engines, with per-transaction timeout abort.
// Revision : 1.0 - initial release
// ============================================================================

module pcie_rq_channel #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 9,
    parameter int PW             = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    reqValid,
    input  logic [NUM_REQ*PW-1:0] reqPayload,
    output logic [NUM_REQ-1:0]    reqReady,
    output logic [NUM_REQ-1:0]    reqErr,
    output logic                  rqValid,
    output logic [PW-1:0]         rqPayload,
    input  logic                  rqReady,
    input  logic                  rqErr,
    output logic [NUM_REQ-1:0]    grant,
    output logic                  timeoutFlag,
    input  logic                  timeoutClr
);
    localparam int c_IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CNT_W-1:0] c_TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

    state_t              r_state;
    logic [c_IDXW-1:0]   r_ptr;
    logic [c_IDXW-1:0]   r_owner;
    logic [CNT_W-1:0]    r_cnt;
    logic [NUM_REQ-1:0]  r_grant;
    logic                r_valid;
    logic [PW-1:0]       r_payload;
    logic                r_flag;

    logic                w_any;
    logic [c_IDXW-1:0]   w_sel;
    logic                w_busy;
    logic                w_timeoutHit;
    logic                w_done;

    // Search starts just after the last owner so every waiting requester is
    // reached within NUM_REQ grants.
    always_comb begin
        int j;
        j     = 0;
        w_any = 1'b0;
        w_sel = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            j = int'(r_ptr) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!w_any && reqValid[c_IDXW'(j)]) begin
                w_any = 1'b1;
                w_sel = c_IDXW'(j);
            end
        end
    end

    assign w_busy       = (r_state == S_BUSY);
    assign w_timeoutHit = w_busy && !rqReady && (r_cnt == c_TO_LAST);
    assign w_done       = w_busy && (rqReady || w_timeoutHit);

    assign reqReady    = w_done ? r_grant : '0;
    assign reqErr      = (w_done && (rqReady ? rqErr : 1'b1)) ? r_grant : '0;
    assign rqValid     = r_valid;
    assign rqPayload   = r_payload;
    assign grant       = r_grant;
    assign timeoutFlag = r_flag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_ptr     <= c_IDXW'(NUM_REQ - 1);
            r_owner   <= '0;
            r_cnt     <= '0;
            r_grant   <= '0;
            r_valid   <= 1'b0;
            r_payload <= '0;
            r_flag    <= 1'b0;
        end else begin
            // A fresh timeout outranks a simultaneous clear.
            if (w_timeoutHit)    r_flag <= 1'b1;
            else if (timeoutClr) r_flag <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_state   <= S_BUSY;
                        r_owner   <= w_sel;
                        r_grant   <= NUM_REQ'(1) << w_sel;
                        r_valid   <= 1'b1;
                        r_payload <= reqPayload[int'(w_sel)*PW +: PW];
                        r_cnt     <= '0;
                    end
                end
                S_BUSY: begin
                    if (w_done) begin
                        r_state <= S_IDLE;
                        r_valid <= 1'b0;
                        r_grant <= '0;
                        r_ptr   <= r_owner;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

module pcie_rq_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 9
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      ReqRdValid,
    input  logic [NUM_REQ*64-1:0]   ReqRdAddr,
    output logic [NUM_REQ-1:0]      ReqRdReady,
    output logic [NUM_REQ-1:0]      ReqRdErr,
    output logic [127:0]            ReqRdData,
    input  logic [NUM_REQ-1:0]      ReqWrValid,
    input  logic [NUM_REQ*64-1:0]   ReqWrAddr,
    input  logic [NUM_REQ*128-1:0]  ReqWrData,
    output logic [NUM_REQ-1:0]      ReqWrReady,
    output logic [NUM_REQ-1:0]      ReqWrErr,
    output logic                    RdRqValid,
    output logic [63:0]             RdRqAddr,
    input  logic [127:0]            RdRqData,
    input  logic                    RdRqReady,
    input  logic                    RdRqErr,
    output logic                    WrRqValid,
    output logic [63:0]             WrRqAddr,
    output logic [127:0]            WrRqData,
    input  logic                    WrRqReady,
    input  logic                    WrRqErr,
    output logic [NUM_REQ-1:0]      RdGrant,
    output logic [NUM_REQ-1:0]      WrGrant,
    output logic                    RdTimeout,
    output logic                    WrTimeout,
    input  logic                    TimeoutClr
);
    localparam int c_WPW = 192;

    logic [NUM_REQ*c_WPW-1:0] w_wrPayload;
    logic [c_WPW-1:0]         w_wrRqPayload;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_wrPayload
        assign w_wrPayload[i*c_WPW +: c_WPW] = {ReqWrData[i*128 +: 128], ReqWrAddr[i*64 +: 64]};
    end

    pcie_rq_channel #(
        .NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_W(CNT_W), .PW(64)
    ) u_rd (
        .clk(clk), .rst_n(rst_n),
        .reqValid(ReqRdValid), .reqPayload(ReqRdAddr),
        .reqReady(ReqRdReady), .reqErr(ReqRdErr),
        .rqValid(RdRqValid), .rqPayload(RdRqAddr),
        .rqReady(RdRqReady), .rqErr(RdRqErr),
        .grant(RdGrant), .timeoutFlag(RdTimeout), .timeoutClr(TimeoutClr)
    );

    pcie_rq_channel #(
        .NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_W(CNT_W), .PW(c_WPW)
    ) u_wr (
        .clk(clk), .rst_n(rst_n),
        .reqValid(ReqWrValid), .reqPayload(w_wrPayload),
        .reqReady(ReqWrReady), .reqErr(ReqWrErr),
        .rqValid(WrRqValid), .rqPayload(w_wrRqPayload),
        .rqReady(WrRqReady), .rqErr(WrRqErr),
        .grant(WrGrant), .timeoutFlag(WrTimeout), .timeoutClr(TimeoutClr)
    );

    assign WrRqAddr = w_wrRqPayload[63:0];
    assign WrRqData = w_wrRqPayload[191:64];

    // Read data is only forwarded on a genuine downstream completion.
    assign ReqRdData = ((|RdGrant) && RdRqReady) ? RdRqData : '0;
endmodule

`default_nettype wire
